// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, lane widths, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_arb_pkg;

    localparam int BE_WIDTH   = 4;
    localparam int DATA_WIDTH = 32;

    // Port indices; the read tag stores one of these.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [BE_WIDTH-1:0]   be_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // An all-zero byte-enable vector encodes a read.
    function automatic logic is_read(input be_t we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus of the data-memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/payload until their gnt; memory side has none.
// Ports: p0_* = CPU memory stage, p1_* = loader/debug DMA, mem_* = data memory.
// Modport slave is the arbiter's view; modport master is the requesters+memory view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    import mem_arb_pkg::*;

    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    be_t                   p0_we;
    data_t                 p0_wdata;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    data_t                 p0_rdata;

    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    be_t                   p1_we;
    data_t                 p1_wdata;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    data_t                 p1_rdata;

    logic                  mem_do_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    be_t                   mem_do_write_byte;
    data_t                 mem_write_data;
    data_t                 mem_read_data;

    modport slave (
        input  p0_req, p0_addr, p0_we, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_addr, p1_we, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_do_read, mem_addr, mem_do_write_byte, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output p0_req, p0_addr, p0_we, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_addr, p1_we, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_do_read, mem_addr, mem_do_write_byte, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way grant selection with starvation counter (default) or round-robin (MEM_ARB_RR_EN).
// Latency: grants are combinational from req0/req1 and the registered arbitration state.
// Backpressure: the losing requester simply sees no gnt and must keep requesting.
// Ports: clk, rst_n, req0/req1 in; gnt0/gnt1 out (one-hot or zero, forced 0 in reset).
// Build option: define MEM_ARB_RR_EN for round-robin contention resolution.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic p1_wins;

    // Grants are gated by rst_n so nothing reaches memory while reset is held.
    assign gnt1 = rst_n && p1_wins;
    assign gnt0 = rst_n && req0 && !p1_wins;

`ifdef MEM_ARB_RR_EN
    // rr_last holds the last granted port; on contention the other one wins.
    logic rr_last;

    always_comb begin
        p1_wins = 1'b0;
        if (req0 && req1) begin
            p1_wins = (rr_last == PORT_CPU);
        end else begin
            p1_wins = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= PORT_DMA;
        end else if (gnt0 || gnt1) begin
            rr_last <= gnt1 ? PORT_DMA : PORT_CPU;
        end
    end
`else
    // Port 0 has priority, but after STARVE_LIMIT consecutive contested wins
    // port 1 is forced through once.
    logic [3:0] starve_cnt;
    logic       force_p1;

    assign force_p1 = (starve_cnt == 4'(STARVE_LIMIT));

    always_comb begin
        p1_wins = 1'b0;
        if (req1) begin
            p1_wins = !req0 || force_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!req1 || gnt1) begin
            starve_cnt <= '0;
        end else if (gnt0 && !force_p1) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported byte-writable data memory between CPU (port 0) and DMA (port 1).
// Latency: grant same cycle as req; read data/rvalid exactly one cycle after the grant.
// Backpressure: a non-granted requester holds req and payload; one access per cycle.
// Ports: clk, rst_n (async, active-low); bus (mem_arbiter_if.slave) carrying p0_*, p1_*
//        requester signals and mem_* memory strobes/address/data.
// Build option: define MEM_ARB_RR_EN for round-robin contention instead of fixed priority
//               with a starvation limit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_arbiter_if.slave        bus
);

    logic                  gnt0;
    logic                  gnt1;
    logic [ADDR_WIDTH-1:0] win_addr;
    be_t                   win_we;
    data_t                 win_wdata;
    logic                  rd_pend;
    logic                  rd_port;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (bus.p0_req),
        .req1 (bus.p1_req),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign bus.p0_gnt = gnt0;
    assign bus.p1_gnt = gnt1;

    // Winner's payload; an idle cycle drives all zeros toward memory.
    always_comb begin
        win_addr  = '0;
        win_we    = '0;
        win_wdata = '0;
        if (gnt0) begin
            win_addr  = bus.p0_addr;
            win_we    = bus.p0_we;
            win_wdata = bus.p0_wdata;
        end else if (gnt1) begin
            win_addr  = bus.p1_addr;
            win_we    = bus.p1_we;
            win_wdata = bus.p1_wdata;
        end
    end

    assign bus.mem_addr          = win_addr;
    assign bus.mem_do_write_byte = win_we;
    assign bus.mem_write_data    = win_wdata;
    assign bus.mem_do_read       = (gnt0 || gnt1) && is_read(win_we);

    // Read tag: remembers who issued the read so the one-cycle-late data is
    // flagged to the right requester. Async reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_port <= PORT_CPU;
        end else begin
            rd_pend <= bus.mem_do_read;
            if (bus.mem_do_read) begin
                rd_port <= gnt1 ? PORT_DMA : PORT_CPU;
            end
        end
    end

    assign bus.p0_rvalid = rd_pend && (rd_port == PORT_CPU);
    assign bus.p1_rvalid = rd_pend && (rd_port == PORT_DMA);
    assign bus.p0_rdata  = bus.mem_read_data;
    assign bus.p1_rdata  = bus.mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: requesters hold their request until granted.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) mif ();

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (mif)
    );

    // ---------------- memory model (environment) ----------------
    logic [31:0] mem [int];

    function automatic logic [31:0] init_word(input int w);
        return 32'hA5C3_0000 + 32'(w);
    endfunction

    function automatic logic [31:0] mem_get(input int w);
        if (mem.exists(w)) return mem[w];
        return init_word(w);
    endfunction

    always @(posedge clk) begin : mem_model
        logic [31:0] v;
        int          w;
        w = int'(mif.mem_addr >> 2);
        if (mif.mem_do_read) mif.mem_read_data <= mem_get(w);
        if (mif.mem_do_write_byte != 4'b0000) begin
            v = mem_get(w);
            for (int b = 0; b < 4; b++)
                if (mif.mem_do_write_byte[b]) v[8*b +: 8] = mif.mem_write_data[8*b +: 8];
            mem[w] = v;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int port, input logic req, input logic [31:0] addr,
                         input logic [3:0] we, input logic [31:0] wd);
        if (port == 0) begin
            mif.p0_req = req; mif.p0_addr = addr; mif.p0_we = we; mif.p0_wdata = wd;
        end else begin
            mif.p1_req = req; mif.p1_addr = addr; mif.p1_we = we; mif.p1_wdata = wd;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h0000_1004, 4'hF, 32'h1111_2222);
        #2;
        n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== 2'b00) $display("FAIL rst_gnt got %b want 00", {mif.p0_gnt, mif.p1_gnt}); else n_pass++;
        n_checks++; if (mif.mem_do_read !== 1'b0) $display("FAIL rst_do_read got %b want 0", mif.mem_do_read); else n_pass++;
        n_checks++; if (mif.mem_do_write_byte !== 4'h0) $display("FAIL rst_wbe got %h want 0", mif.mem_do_write_byte); else n_pass++;
        n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b00) $display("FAIL rst_rvalid got %b want 00", {mif.p0_rvalid, mif.p1_rvalid}); else n_pass++;
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [31:0] exp;
        exp = init_word(32'h1000 >> 2);
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
        #1;
        n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== 2'b10) $display("FAIL rd0_gnt got %b want 10", {mif.p0_gnt, mif.p1_gnt}); else n_pass++;
        n_checks++; if (mif.mem_do_read !== 1'b1 || mif.mem_addr !== 32'h1000) $display("FAIL rd0_strobe got rd=%b addr=%h want rd=1 addr=1000", mif.mem_do_read, mif.mem_addr); else n_pass++;
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b10) $display("FAIL rd0_rvalid got %b want 10", {mif.p0_rvalid, mif.p1_rvalid}); else n_pass++;
        n_checks++; if (mif.p0_rdata !== exp) $display("FAIL rd0_rdata got %h want %h", mif.p0_rdata, exp); else n_pass++;
        n_checks++; if (mif.mem_do_read !== 1'b0 || mif.mem_addr !== 32'h0) $display("FAIL idle_bus got rd=%b addr=%h want rd=0 addr=0", mif.mem_do_read, mif.mem_addr); else n_pass++;
    endtask

    task automatic test_write_readback();
        logic [31:0] init;
        logic [31:0] exp;
        init = init_word(32'h1004 >> 2);
        exp  = {init[31:16], 16'hBEEF};
        @(negedge clk);
        drive(1, 1'b1, 32'h0000_1004, 4'b0011, 32'hDEAD_BEEF);
        #1;
        n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== 2'b01) $display("FAIL wr1_gnt got %b want 01", {mif.p0_gnt, mif.p1_gnt}); else n_pass++;
        n_checks++; if (mif.mem_do_write_byte !== 4'b0011 || mif.mem_do_read !== 1'b0 || mif.mem_write_data !== 32'hDEAD_BEEF) $display("FAIL wr1_bus got wbe=%b rd=%b wd=%h want 0011/0/deadbeef", mif.mem_do_write_byte, mif.mem_do_read, mif.mem_write_data); else n_pass++;
        @(negedge clk);
        drive(1, 1'b1, 32'h0000_1004, 4'b0000, 32'h0);
        #1;
        n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b00) $display("FAIL wr1_noresp got %b want 00", {mif.p0_rvalid, mif.p1_rvalid}); else n_pass++;
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_checks++; if (mif.p1_rvalid !== 1'b1 || mif.p1_rdata !== exp) $display("FAIL wr1_readback got v=%b d=%h want 1 %h", mif.p1_rvalid, mif.p1_rdata, exp); else n_pass++;
    endtask

    task automatic test_contention();
        int   a0, a1, prev;
        logic exp1;
        logic [31:0] prev_addr;
        a0 = 0; a1 = 0; prev = -1; prev_addr = 32'h0;
        reset_dut();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'h3000 + 32'(4*a0), 4'h0, 32'h0);
            drive(1, 1'b1, 32'h3100 + 32'(4*a1), 4'h0, 32'h0);
            #1;
`ifdef MEM_ARB_RR_EN
            exp1 = (k % 2) == 1;
`else
            exp1 = (k % (LIMIT + 1)) == LIMIT;
`endif
            n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== {!exp1, exp1}) $display("FAIL contend_gnt k=%0d got %b want %b", k, {mif.p0_gnt, mif.p1_gnt}, {!exp1, exp1}); else n_pass++;
            if (prev >= 0) begin
                n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== ((prev == 1) ? 2'b01 : 2'b10) || mif.p0_rdata !== init_word(int'(prev_addr >> 2)))
                    $display("FAIL contend_rd k=%0d got v=%b d=%h want port%0d d=%h", k, {mif.p0_rvalid, mif.p1_rvalid}, mif.p0_rdata, prev, init_word(int'(prev_addr >> 2)));
                else n_pass++;
            end
            prev      = exp1 ? 1 : 0;
            prev_addr = exp1 ? 32'h3100 + 32'(4*a1) : 32'h3000 + 32'(4*a0);
            if (exp1) a1++; else a0++;
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_same_word();
        reset_dut();
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_1008, 4'hF, 32'h1234_5678);
        drive(1, 1'b1, 32'h0000_1008, 4'h0, 32'h0);
        #1;
        n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== 2'b10 || mif.mem_do_write_byte !== 4'hF) $display("FAIL same_first got gnt=%b wbe=%h want 10 f", {mif.p0_gnt, mif.p1_gnt}, mif.mem_do_write_byte); else n_pass++;
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== 2'b01 || mif.mem_do_read !== 1'b1) $display("FAIL same_second got gnt=%b rd=%b want 01 1", {mif.p0_gnt, mif.p1_gnt}, mif.mem_do_read); else n_pass++;
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b01 || mif.p1_rdata !== 32'h1234_5678) $display("FAIL same_data got v=%b d=%h want 01 12345678", {mif.p0_rvalid, mif.p1_rvalid}, mif.p1_rdata); else n_pass++;
    endtask

    task automatic test_reset_pending();
        reset_dut();
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
        #1;
        n_checks++; if (mif.p0_gnt !== 1'b1) $display("FAIL rstpend_gnt got %b want 1", mif.p0_gnt); else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b00) $display("FAIL rstpend_rvalid got %b want 00", {mif.p0_rvalid, mif.p1_rvalid}); else n_pass++;
        n_checks++; if ({mif.p0_gnt, mif.mem_do_read, mif.mem_do_write_byte} !== 6'b0) $display("FAIL rstpend_strobes got gnt=%b rd=%b wbe=%h want 0", mif.p0_gnt, mif.mem_do_read, mif.mem_do_write_byte); else n_pass++;
        @(negedge clk);
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== 2'b00) $display("FAIL rstpend_after got %b want 00", {mif.p0_rvalid, mif.p1_rvalid}); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic        pr [2];
        logic [31:0] pa [2];
        logic [3:0]  pw [2];
        logic [31:0] pd [2];
        logic [31:0] ref_mem [int];
        int          starve;
        logic        last;
        logic        exp_v, exp_port;
        logic [31:0] exp_dat;
        logic        g0, g1, w1, cont;
        logic [31:0] e_addr, v;
        logic [3:0]  e_we;
        logic        e_rd;
        int          w;
        reset_dut();
        starve = 0; last = 1'b1; exp_v = 1'b0; exp_port = 1'b0; exp_dat = 32'h0;
        for (int p = 0; p < 2; p++) begin pr[p] = 1'b0; pa[p] = 0; pw[p] = 0; pd[p] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pr[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        pr[p] = 1'b1;
                        pa[p] = 32'h2000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                        pw[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                        pd[p] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pr[p] = 1'b0;
                end
                drive(p, pr[p], pa[p], pw[p], pd[p]);
            end
            #1;
            cont = pr[0] && pr[1];
`ifdef MEM_ARB_RR_EN
            w1 = (last == 1'b0);
`else
            w1 = (starve == LIMIT);
`endif
            g1 = pr[1] && (!pr[0] || w1);
            g0 = pr[0] && !(cont && w1);
            e_addr = g0 ? pa[0] : (g1 ? pa[1] : 32'h0);
            e_we   = g0 ? pw[0] : (g1 ? pw[1] : 4'h0);
            e_rd   = (g0 || g1) && (e_we == 4'h0);
            n_checks++; if ({mif.p0_gnt, mif.p1_gnt} !== {g0, g1}) $display("FAIL rnd_gnt cyc=%0d got %b want %b", cyc, {mif.p0_gnt, mif.p1_gnt}, {g0, g1}); else n_pass++;
            n_checks++; if (mif.mem_addr !== e_addr || mif.mem_do_write_byte !== e_we || mif.mem_do_read !== e_rd)
                $display("FAIL rnd_bus cyc=%0d got a=%h we=%h rd=%b want a=%h we=%h rd=%b", cyc, mif.mem_addr, mif.mem_do_write_byte, mif.mem_do_read, e_addr, e_we, e_rd);
            else n_pass++;
            n_checks++; if ({mif.p0_rvalid, mif.p1_rvalid} !== {exp_v && !exp_port, exp_v && exp_port}) $display("FAIL rnd_rvalid cyc=%0d got %b want %b", cyc, {mif.p0_rvalid, mif.p1_rvalid}, {exp_v && !exp_port, exp_v && exp_port}); else n_pass++;
            if (exp_v) begin
                n_checks++; if ((exp_port ? mif.p1_rdata : mif.p0_rdata) !== exp_dat) $display("FAIL rnd_rdata cyc=%0d got %h want %h", cyc, exp_port ? mif.p1_rdata : mif.p0_rdata, exp_dat); else n_pass++;
            end
            // advance the reference model
            exp_v = 1'b0;
            if (g0 || g1) begin
                w = int'(e_addr >> 2);
                v = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
                if (e_rd) begin
                    exp_v = 1'b1; exp_port = g1; exp_dat = v;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (e_we[b]) v[8*b +: 8] = (g0 ? pd[0][8*b +: 8] : pd[1][8*b +: 8]);
                    ref_mem[w] = v;
                end
                last = g1;
            end
            if (!pr[1] || g1) starve = 0;
            else if (g0 && starve < LIMIT) starve++;
            if (g0) pr[0] = 1'b0;
            if (g1) pr[1] = 1'b0;
        end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_same_word();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
